uart_tx_queue: RTL and testbench

Byte transmit queue between the UART command processor and the `uart_hs` transmitter. It buffers bytes pushed by the command logic, which may push several bytes back-to-back (for example, SDRAM long-read dumps). It then issues them to `uart_hs` as single-cycle `uart_send` pulses, spaced by a fixed byte period. This replaces ad-hoc per-command pacing counters with one shared, back-pressured path.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 85 ++++++++
 rtl/uart_tx_queue.sv | 91 +++++++++
 tb/tb_uart_tx_queue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and defaults for the transmit queue.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_CLKS_PER_BYTE_DEFAULT = 300;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } pacer_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock byte FIFO with registered flags and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [7:0]               i_push_data,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    input  logic                     i_clr_overflow
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    localparam logic [c_lvl_w-1:0] c_depth = c_lvl_w'(DEPTH);

    uart_byte_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic [c_lvl_w-1:0] w_level_nxt;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic               w_drop;

    // Acceptance uses the flags registered before this cycle's pop.
    assign w_push_ok = i_push & ~r_full;
    assign w_pop_ok  = i_pop & ~r_empty;
    assign w_drop    = i_push & r_full;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_depth);
            r_empty <= (w_level_nxt == '0);
            if (w_drop)              r_overflow <= 1'b1;
            else if (i_clr_overflow) r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_queue
// Brief    : Buffers command bytes and paces them out to uart_hs.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int CLKS_PER_BYTE = UART_CLKS_PER_BYTE_DEFAULT
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   push,
    input  logic [7:0]             push_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_overflow,
    output logic                   uart_send,
    output logic [7:0]             tx_data,
    output logic                   tx_busy
);

    localparam int c_gap_w = (CLKS_PER_BYTE > 2) ? $clog2(CLKS_PER_BYTE - 1) : 1;
    localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(CLKS_PER_BYTE - 2);

    pacer_state_t       r_state;
    pacer_state_t       w_state_nxt;
    logic [c_gap_w-1:0] r_gap_cnt;
    logic               w_pop;
    uart_byte_t         w_head;
    uart_byte_t         r_tx_data;
    logic               r_uart_send;

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (sys_clk),
        .rst            (sys_rst),
        .i_push         (push),
        .i_push_data    (push_data),
        .i_pop          (w_pop),
        .o_head         (w_head),
        .o_full         (full),
        .o_empty        (empty),
        .o_level        (level),
        .o_overflow     (overflow),
        .i_clr_overflow (clr_overflow)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: if (!empty) w_state_nxt = SEND;
            SEND: begin
                w_pop       = 1'b1;
                w_state_nxt = GAP;
            end
            GAP:  if (r_gap_cnt == '0) w_state_nxt = empty ? IDLE : SEND;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are loaded on entry to SEND so the pulse and data coincide with it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_gap_cnt   <= '0;
            r_uart_send <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_uart_send <= (w_state_nxt == SEND);
            if (w_state_nxt == SEND) r_tx_data <= w_head;
            if (r_state == SEND)
                r_gap_cnt <= c_gap_load;
            else if (r_state == GAP && r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

    assign uart_send = r_uart_send;
    assign tx_data   = r_tx_data;
    assign tx_busy   = !empty || (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_queue
// Brief    : Directed self-checking bench for uart_tx_queue (DEPTH 16, 300 clk/byte).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int CPB   = 300;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       push = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       full, empty, overflow, uart_send, tx_busy;
    logic [4:0] level;
    logic [7:0] tx_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int   dbl_cnt = 0;
    int   txd_chg = 0;
    logic prev_send = 1'b0;
    logic prev_rst = 1'b1;
    logic [7:0] prev_txd = 8'h00;

    uart_tx_queue #(.DEPTH(DEPTH), .CLKS_PER_BYTE(CPB)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .push         (push),
        .push_data    (push_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .uart_send    (uart_send),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Pulse monitor: logs every send with its cycle and tracks protocol breaches.
    always @(negedge sys_clk) begin
        if (uart_send === 1'b1) begin
            rx_q.push_back(tx_data);
            rx_t.push_back(cyc);
        end
        if (uart_send === 1'b1 && prev_send) dbl_cnt++;
        if (uart_send !== 1'b1 && !prev_rst && tx_data !== prev_txd) txd_chg++;
        prev_send = (uart_send === 1'b1);
        prev_txd  = tx_data;
        prev_rst  = sys_rst;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_neg(input int t);
        do @(negedge sys_clk); while (cyc < t);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (level !== 5'd0)     begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (uart_send !== 1'b0) begin errors++; $display("FAIL reset_uart_send got %b exp 0", uart_send); end
        checks++; if (tx_data !== 8'h00)  begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
        checks++; if (tx_busy !== 1'b0)   begin errors++; $display("FAIL reset_tx_busy got %b exp 0", tx_busy); end
    endtask

    task automatic test_single();
        int n;
        rx_q.delete(); rx_t.delete();
        tick(); n = cyc;
        push = 1'b1; push_data = 8'hA5;
        tick(); push = 1'b0;
        wait_neg(n + 1);
        checks++; if (level !== 5'd1)     begin errors++; $display("FAIL single_level got %0d exp 1", level); end
        checks++; if (uart_send !== 1'b0) begin errors++; $display("FAIL single_early_send got %b exp 0", uart_send); end
        wait_neg(n + 2);
        checks++; if (uart_send !== 1'b1) begin errors++; $display("FAIL single_send got %b exp 1", uart_send); end
        checks++; if (tx_data !== 8'hA5)  begin errors++; $display("FAIL single_data got %h exp a5", tx_data); end
        wait_neg(n + 3);
        checks++; if (uart_send !== 1'b0) begin errors++; $display("FAIL single_pulse_len got %b exp 0", uart_send); end
        checks++; if (tx_data !== 8'hA5)  begin errors++; $display("FAIL single_data_hold got %h exp a5", tx_data); end
        wait_neg(n + 301);
        checks++; if (tx_busy !== 1'b1)   begin errors++; $display("FAIL single_busy_gap got %b exp 1", tx_busy); end
        wait_neg(n + 302);
        checks++; if (tx_busy !== 1'b0)   begin errors++; $display("FAIL single_busy_fall got %b exp 0", tx_busy); end
        checks++;
        if (rx_q.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", rx_q.size()); end
        else begin
            checks++; if (rx_t[0] != n + 2) begin errors++; $display("FAIL single_time got %0d exp %0d", rx_t[0], n + 2); end
        end
    endtask

    task automatic test_burst();
        int n;
        int peak;
        rx_q.delete(); rx_t.delete();
        peak = 0;
        tick(); n = cyc;
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; push_data = 8'(i + 1);
            tick();
            if (int'(level) > peak) peak = int'(level);
        end
        push = 1'b0;
        repeat (3) begin
            @(negedge sys_clk);
            if (int'(level) > peak) peak = int'(level);
        end
        checks++; if (peak != 7) begin errors++; $display("FAIL burst_peak_level got %0d exp 7", peak); end
        wait_neg(n + 2 + 7 * CPB + 1);
        checks++;
        if (rx_q.size() != 8) begin errors++; $display("FAIL burst_count got %0d exp 8", rx_q.size()); end
        else begin
            for (int k = 0; k < 8; k++) begin
                checks++; if (rx_q[k] !== 8'(k + 1)) begin errors++; $display("FAIL burst_data[%0d] got %h exp %h", k, rx_q[k], 8'(k + 1)); end
                checks++; if (rx_t[k] != n + 2 + k * CPB) begin errors++; $display("FAIL burst_time[%0d] got %0d exp %0d", k, rx_t[k], n + 2 + k * CPB); end
            end
        end
        wait_neg(n + 2 + 8 * CPB);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL burst_idle got %b exp 0", tx_busy); end
    endtask

    task automatic test_full_overflow();
        int n;
        rx_q.delete(); rx_t.delete();
        tick(); n = cyc;
        push = 1'b1; push_data = 8'h10;
        tick(); push = 1'b0;
        repeat (2) tick();
        // First byte is now in its gap: 17 pushes in cycles n+3..n+19.
        for (int i = 0; i < 17; i++) begin
            push = 1'b1; push_data = 8'(8'h20 + i);
            tick();
        end
        push = 1'b0;
        @(negedge sys_clk);
        checks++; if (level !== 5'd16)   begin errors++; $display("FAIL full_level got %0d exp 16", level); end
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL full_flag got %b exp 1", full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow_set got %b exp 1", overflow); end
        wait_neg(n + 25);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow_sticky got %b exp 1", overflow); end
        tick();
        clr_overflow = 1'b1;
        tick(); clr_overflow = 1'b0;
        @(negedge sys_clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_clr got %b exp 0", overflow); end
        while (cyc < n + 302) tick();
        checks++; if (uart_send !== 1'b1) begin errors++; $display("FAIL full_pop_cycle got %b exp 1", uart_send); end
        // Push into full during the pop, with a clear in the same cycle.
        push = 1'b1; push_data = 8'hEE; clr_overflow = 1'b1;
        tick(); push = 1'b0; clr_overflow = 1'b0;
        checks++; if (level !== 5'd15)   begin errors++; $display("FAIL full_pop_level got %0d exp 15", level); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL full_pop_flag got %b exp 0", full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_set_wins got %b exp 1", overflow); end
        clr_overflow = 1'b1;
        tick(); clr_overflow = 1'b0;
        wait_neg(n + 2 + 16 * CPB + 1);
        checks++;
        if (rx_q.size() != 17) begin errors++; $display("FAIL full_drain_count got %0d exp 17", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'h10) begin errors++; $display("FAIL full_drain[0] got %h exp 10", rx_q[0]); end
            for (int k = 1; k < 17; k++) begin
                checks++; if (rx_q[k] !== 8'(8'h1F + k)) begin errors++; $display("FAIL full_drain[%0d] got %h exp %h", k, rx_q[k], 8'(8'h1F + k)); end
            end
        end
        wait_neg(n + 2 + 17 * CPB);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL full_idle got %b exp 0", tx_busy); end
    endtask

    task automatic test_wrap();
        int idx;
        int t0;
        int k;
        rx_q.delete(); rx_t.delete();
        tick(); t0 = cyc; idx = 0;
        while (idx < 40 && cyc < t0 + 20000) begin
            if (full === 1'b0) begin
                push = 1'b1; push_data = 8'(idx * 37 + 5); idx++;
            end else begin
                push = 1'b0;
            end
            tick();
        end
        push = 1'b0;
        checks++; if (idx != 40) begin errors++; $display("FAIL wrap_pushes got %0d exp 40", idx); end
        k = 0;
        while (tx_busy !== 1'b0 && k < 8000) begin
            @(negedge sys_clk); k++;
        end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL wrap_drain_timeout got busy %b exp 0", tx_busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got %b exp 0", overflow); end
        checks++;
        if (rx_q.size() != 40) begin errors++; $display("FAIL wrap_count got %0d exp 40", rx_q.size()); end
        else begin
            for (int i = 0; i < 40; i++) begin
                checks++; if (rx_q[i] !== 8'(i * 37 + 5)) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, rx_q[i], 8'(i * 37 + 5)); end
                if (i > 0) begin
                    checks++; if (rx_t[i] - rx_t[i-1] != CPB) begin errors++; $display("FAIL wrap_spacing[%0d] got %0d exp %0d", i, rx_t[i] - rx_t[i-1], CPB); end
                end
            end
        end
    endtask

    task automatic test_midgap_reset();
        int n;
        rx_q.delete(); rx_t.delete();
        tick(); n = cyc;
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_data = 8'(8'hC0 + i);
            tick();
        end
        push = 1'b0;
        while (cyc < n + 52) tick();
        sys_rst = 1'b1;
        repeat (2) tick();
        sys_rst = 1'b0;
        wait_neg(n + 2 + 3 * CPB);
        checks++; if (rx_q.size() != 1)   begin errors++; $display("FAIL midrst_pulses got %0d exp 1", rx_q.size()); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL midrst_empty got %b exp 1", empty); end
        checks++; if (level !== 5'd0)     begin errors++; $display("FAIL midrst_level got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL midrst_overflow got %b exp 0", overflow); end
        checks++; if (tx_busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy got %b exp 0", tx_busy); end
        checks++; if (tx_data !== 8'h00)  begin errors++; $display("FAIL midrst_tx_data got %h exp 00", tx_data); end
    endtask

    task automatic test_protocol();
        checks++; if (dbl_cnt != 0) begin errors++; $display("FAIL proto_back_to_back_send got %0d exp 0", dbl_cnt); end
        checks++; if (txd_chg != 0) begin errors++; $display("FAIL proto_tx_data_change got %0d exp 0", txd_chg); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_overflow();
        test_wrap();
        test_midgap_reset();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
